wb_arbiter_n: RTL and testbench
===============================

Name: wb_arbiter_n

Overview:
Parametrised N-master to 1-slave Wishbone B4 arbiter. It is the successor to the fixed two-master data-over-instruction mux. It adds a registered grant locked for the whole bus cycle (CYC), selectable fixed-priority or round-robin arbitration, and an optional stall timeout that returns ERR. It sits between the core's masters (instruction fetch, data, DMA/debug) and the memory/peripheral interconnect.

Parameters:
N_MASTERS, 2, number of master ports (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width
RR_MODE, 0, 0 = fixed priority (highest index wins, matching existing data-over-inst order); 1 = round-robin
TIMEOUT, 0, cycles a granted STB may wait for ACK before ERR; 0 disables

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
m_cyc  in  N_MASTERS  master CYC
m_stb  in  N_MASTERS  master STB
m_we  in  N_MASTERS  master WE
m_adr  in  N_MASTERS*ADDR_W  master ADR, master i at [i*ADDR_W +: ADDR_W]
m_dat_o  in  N_MASTERS*DATA_W  master write data, same packing
m_dat_i  out  DATA_W  read data broadcast to all masters (= s_dat_i)
m_ack  out  N_MASTERS  per-master ACK
m_err  out  N_MASTERS  per-master ERR (timeout)
s_cyc  out  1  slave CYC
s_stb  out  1  slave STB
s_we  out  1  slave WE
s_adr  out  ADDR_W  slave ADR
s_dat_o  out  DATA_W  slave write data
s_dat_i  in  DATA_W  slave read data
s_ack  in  1  slave ACK
grant  out  N_MASTERS  one-hot current owner, 0 when idle

Behaviour:
- States: IDLE, BUSY. Reset: state = IDLE, grant = 0, rr_last = N_MASTERS-1, timeout counter = 0, m_ack = m_err = 0, s_cyc = s_stb = s_we = 0.
- IDLE: if any m_cyc is high, register the winner into grant and go to BUSY. Arbitration latency is 1 cycle (grant is visible the cycle after the request). No m_cyc: stay.
- Fixed priority: highest index with m_cyc wins.
- Round-robin: search from rr_last+1 upward with wrap-around; rr_last is updated to the winner on grant. After reset, master 0 wins the first tie.
- BUSY: s_cyc/s_stb/s_we/s_adr/s_dat_o are combinational copies of the granted master's signals. m_ack[g] = s_ack & m_stb[g]; all other m_ack = 0. Non-granted requests are ignored; grant is held while m_cyc[g] is high, across any number of STB beats.
- Release: m_cyc[g] low -> IDLE, grant = 0 next cycle, s_cyc low immediately (combinational). There is always 1 idle cycle between owners. No same-cycle re-grant.
- Timeout (TIMEOUT>0): counter increments each BUSY cycle with s_stb=1 and s_ack=0, and clears on ACK or when STB is low. When counter == TIMEOUT-1 with no ACK:
  - m_err[g] pulses 1 cycle.
  - s_cyc/s_stb are forced low that cycle.
  - state -> IDLE.
  - A late s_ack in that cycle is not forwarded.
- Simultaneous s_ack and timeout-reach: ACK wins, no ERR.
- Reset mid-cycle: everything returns to reset values asynchronously; in-flight transfer is abandoned.
- With no grant, s_adr/s_dat_o = 0.

Decomposition:
- Package wb_arb_pkg: state enum {ARB_IDLE, ARB_BUSY}, mode constants ARB_FIXED=0 / ARB_RR=1, and a function for the index-to-one-hot conversion.
- Sub-module wb_arb_picker: combinational request vector + rr_last + mode -> one-hot winner and index. This keeps the search logic separately testable.

Test Plan:
- Fixed mode, N=2, m_cyc=2'b11 in the same cycle -> grant=2'b10 next cycle; master 0 gets no ACK until master 1 drops CYC, then grant=0 for 1 cycle, then grant=2'b01.
- RR mode, N=4, all four hold CYC and drop after 1 ACK each -> grant order 0001, 0010, 0100, 1000, 0001.
- Burst lock: master 0 issues 4 STB beats with CYC held while master 1 requests -> grant stays 01 for all 4 ACKs; master 1 is granted only after CYC drops.
- Routing: granted master 1 with adr=0x0000_1000, we=1, dat=0xDEADBEEF -> s_adr/s_dat_o/s_we match; s_ack reaches m_ack[1] only, m_ack[0]=0.
- TIMEOUT=8, slave never ACKs -> m_err[g] pulses exactly 8 cycles after STB; s_cyc is low that cycle; state returns to IDLE. ACK arriving on cycle 8 instead -> m_ack, no m_err.
- Assert rst while BUSY mid-beat -> same cycle grant=0, s_cyc=0; after release, RR restarts with master 0.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the N-master Wishbone arbiter.
package wb_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam bit ARB_FIXED = 1'b0;
  localparam bit ARB_RR    = 1'b1;

  localparam int unsigned MAX_MASTERS = 8;

  function automatic logic [MAX_MASTERS-1:0] idx_to_onehot(input int unsigned idx);
    return MAX_MASTERS'(1) << idx;
  endfunction

endpackage

// File: rtl/wb_arbiter_n_if.sv
// Bus bundle for the arbiter: the slave modport faces the masters,
// the master modport faces the downstream interconnect.
interface wb_arbiter_n_if #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);

  logic [N_MASTERS-1:0]        m_cyc;
  logic [N_MASTERS-1:0]        m_stb;
  logic [N_MASTERS-1:0]        m_we;
  logic [N_MASTERS*ADDR_W-1:0] m_adr;
  logic [N_MASTERS*DATA_W-1:0] m_dat_o;
  logic [DATA_W-1:0]           m_dat_i;
  logic [N_MASTERS-1:0]        m_ack;
  logic [N_MASTERS-1:0]        m_err;
  logic [N_MASTERS-1:0]        grant;

  logic                        s_cyc;
  logic                        s_stb;
  logic                        s_we;
  logic [ADDR_W-1:0]           s_adr;
  logic [DATA_W-1:0]           s_dat_o;
  logic [DATA_W-1:0]           s_dat_i;
  logic                        s_ack;

  modport slave (
    input  m_cyc, m_stb, m_we, m_adr, m_dat_o,
    output m_dat_i, m_ack, m_err, grant
  );

  modport master (
    output s_cyc, s_stb, s_we, s_adr, s_dat_o,
    input  s_dat_i, s_ack
  );

endinterface

// File: rtl/wb_arb_picker.sv
// Combinational winner search: highest-index fixed priority, or round-robin
// starting just after the previous winner.
module wb_arb_picker
  import wb_arb_pkg::*;
#(
  parameter int N_MASTERS = 2,
  localparam int IdxW     = $clog2(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] i_req,
  input  logic [IdxW-1:0]      i_rr_last,
  input  logic                 i_mode,
  output logic [N_MASTERS-1:0] o_onehot,
  output logic [IdxW-1:0]      o_idx
);

  logic w_found;
  int   w_j;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    w_found  = 1'b0;
    w_j      = 0;
    if (i_mode == ARB_RR) begin
      for (int k = 1; k <= N_MASTERS; k++) begin
        w_j = int'(i_rr_last) + k;
        if (w_j >= N_MASTERS) w_j = w_j - N_MASTERS;
        if (!w_found && i_req[w_j]) begin
          w_found = 1'b1;
          o_idx   = IdxW'(w_j);
        end
      end
    end else begin
      // Ascending scan so the highest requesting index is the last write.
      for (int k = 0; k < N_MASTERS; k++) begin
        if (i_req[k]) begin
          w_found = 1'b1;
          o_idx   = IdxW'(k);
        end
      end
    end
    if (w_found) o_onehot = N_MASTERS'(idx_to_onehot(32'(o_idx)));
  end

endmodule

// File: rtl/wb_arbiter_n.sv
// N-master to 1-slave Wishbone B4 arbiter with grant locked for the whole
// CYC, fixed-priority or round-robin selection and an optional stall timeout.
module wb_arbiter_n
  import wb_arb_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int RR_MODE   = 0,
  parameter int TIMEOUT   = 0
) (
  input  logic            clk,
  input  logic            rst,
  wb_arbiter_n_if.slave   io_m,
  wb_arbiter_n_if.master  io_s
);

  localparam int IdxW        = $clog2(N_MASTERS);
  localparam int CntW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TimeoutLast = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam bit Mode        = (RR_MODE != 0) ? ARB_RR : ARB_FIXED;

  arb_state_e           r_state, w_state_nxt;
  logic [N_MASTERS-1:0] r_grant, w_grant_nxt;
  logic [IdxW-1:0]      r_gidx, w_gidx_nxt;
  logic [IdxW-1:0]      r_rr_last, w_rr_last_nxt;
  logic [CntW-1:0]      r_cnt, w_cnt_nxt;

  logic [N_MASTERS-1:0] w_win_oh;
  logic [IdxW-1:0]      w_win_idx;
  logic                 w_busy;
  logic                 w_g_cyc;
  logic                 w_g_stb;
  logic                 w_timeout;

  wb_arb_picker #(
    .N_MASTERS (N_MASTERS)
  ) u_picker (
    .i_req     (io_m.m_cyc),
    .i_rr_last (r_rr_last),
    .i_mode    (Mode),
    .o_onehot  (w_win_oh),
    .o_idx     (w_win_idx)
  );

  assign w_busy  = (r_state == ARB_BUSY);
  assign w_g_cyc = w_busy & io_m.m_cyc[r_gidx];
  assign w_g_stb = w_busy & io_m.m_stb[r_gidx];

  // An ACK landing on the final allowed cycle beats the timeout.
  assign w_timeout = (TIMEOUT > 0) && w_g_cyc && w_g_stb && !io_s.s_ack &&
                     (r_cnt == CntW'(TimeoutLast));

  always_comb begin
    io_s.s_cyc   = w_g_cyc & ~w_timeout;
    io_s.s_stb   = w_g_stb & ~w_timeout;
    io_s.s_we    = w_busy & io_m.m_we[r_gidx];
    io_s.s_adr   = '0;
    io_s.s_dat_o = '0;
    if (w_busy) begin
      io_s.s_adr   = io_m.m_adr[int'(r_gidx)*ADDR_W +: ADDR_W];
      io_s.s_dat_o = io_m.m_dat_o[int'(r_gidx)*DATA_W +: DATA_W];
    end
    io_m.m_dat_i = io_s.s_dat_i;
    io_m.m_ack   = (w_busy && io_s.s_ack) ? (r_grant & io_m.m_stb) : '0;
    io_m.m_err   = w_timeout ? r_grant : '0;
    io_m.grant   = r_grant;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_gidx_nxt    = r_gidx;
    w_rr_last_nxt = r_rr_last;
    w_cnt_nxt     = '0;
    unique case (r_state)
      ARB_IDLE: begin
        if (|io_m.m_cyc) begin
          w_state_nxt   = ARB_BUSY;
          w_grant_nxt   = w_win_oh;
          w_gidx_nxt    = w_win_idx;
          w_rr_last_nxt = w_win_idx;
        end
      end
      ARB_BUSY: begin
        if (!w_g_cyc || w_timeout) begin
          w_state_nxt = ARB_IDLE;
          w_grant_nxt = '0;
          w_gidx_nxt  = '0;
        end else if ((TIMEOUT > 0) && w_g_stb && !io_s.s_ack) begin
          w_cnt_nxt = r_cnt + CntW'(1);
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ARB_IDLE;
      r_grant   <= '0;
      r_gidx    <= '0;
      r_rr_last <= IdxW'(N_MASTERS - 1);
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_gidx    <= w_gidx_nxt;
      r_rr_last <= w_rr_last_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_wb_arbiter_n.sv
// Directed bench: dut_a is 2-master fixed priority with an 8-cycle timeout,
// dut_b is 4-master round-robin without timeout.
module tb_wb_arbiter_n;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 clk = ~clk;

  wb_arbiter_n_if #(.N_MASTERS(2), .ADDR_W(32), .DATA_W(32)) bus_a ();
  wb_arbiter_n_if #(.N_MASTERS(4), .ADDR_W(32), .DATA_W(32)) bus_b ();

  wb_arbiter_n #(
    .N_MASTERS (2),
    .ADDR_W    (32),
    .DATA_W    (32),
    .RR_MODE   (0),
    .TIMEOUT   (8)
  ) dut_a (
    .clk  (clk),
    .rst  (rst_a),
    .io_m (bus_a),
    .io_s (bus_a)
  );

  wb_arbiter_n #(
    .N_MASTERS (4),
    .ADDR_W    (32),
    .DATA_W    (32),
    .RR_MODE   (1),
    .TIMEOUT   (0)
  ) dut_b (
    .clk  (clk),
    .rst  (rst_b),
    .io_m (bus_b),
    .io_s (bus_b)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_vec++;
    if (bus_a.grant !== 2'b00) begin
      n_bad++; $display("FAIL reset_grant_a: got %b want 00", bus_a.grant);
    end
    n_vec++;
    if ({bus_a.s_cyc, bus_a.s_stb, bus_a.s_we} !== 3'b000) begin
      n_bad++; $display("FAIL reset_s_ctl_a: got %b want 000", {bus_a.s_cyc, bus_a.s_stb, bus_a.s_we});
    end
    n_vec++;
    if ({bus_a.m_ack, bus_a.m_err} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_ack_err_a: got %b want 0000", {bus_a.m_ack, bus_a.m_err});
    end
    n_vec++;
    if (bus_b.grant !== 4'b0000) begin
      n_bad++; $display("FAIL reset_grant_b: got %b want 0000", bus_b.grant);
    end
    tick();
    rst_a = 1'b0;
    rst_b = 1'b0;
    tick();
  endtask

  task automatic test_fixed_prio();
    bus_a.m_cyc = 2'b11;
    bus_a.m_stb = 2'b11;
    #1;
    n_vec++;
    if (bus_a.grant !== 2'b00) begin
      n_bad++; $display("FAIL fixed_latency: got %b want 00", bus_a.grant);
    end
    tick();
    n_vec++;
    if (bus_a.grant !== 2'b10) begin
      n_bad++; $display("FAIL fixed_grant_hi: got %b want 10", bus_a.grant);
    end
    bus_a.s_ack = 1'b1;
    #1;
    n_vec++;
    if (bus_a.m_ack !== 2'b10) begin
      n_bad++; $display("FAIL fixed_ack_owner: got %b want 10", bus_a.m_ack);
    end
    tick();
    bus_a.s_ack = 1'b0;
    bus_a.m_cyc = 2'b01;
    bus_a.m_stb = 2'b01;
    #1;
    n_vec++;
    if (bus_a.s_cyc !== 1'b0) begin
      n_bad++; $display("FAIL fixed_release_comb: got %b want 0", bus_a.s_cyc);
    end
    tick();
    n_vec++;
    if (bus_a.grant !== 2'b00) begin
      n_bad++; $display("FAIL fixed_idle_gap: got %b want 00", bus_a.grant);
    end
    tick();
    n_vec++;
    if (bus_a.grant !== 2'b01) begin
      n_bad++; $display("FAIL fixed_grant_lo: got %b want 01", bus_a.grant);
    end
    bus_a.m_cyc = 2'b00;
    bus_a.m_stb = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_routing();
    bus_a.m_adr   = {32'h0000_1000, 32'h0000_2000};
    bus_a.m_dat_o = {32'hDEAD_BEEF, 32'h1234_5678};
    bus_a.m_we    = 2'b10;
    bus_a.m_cyc   = 2'b11;
    bus_a.m_stb   = 2'b11;
    tick();
    n_vec++;
    if (bus_a.s_adr !== 32'h0000_1000) begin
      n_bad++; $display("FAIL route_adr: got %h want 00001000", bus_a.s_adr);
    end
    n_vec++;
    if (bus_a.s_dat_o !== 32'hDEAD_BEEF) begin
      n_bad++; $display("FAIL route_dat: got %h want deadbeef", bus_a.s_dat_o);
    end
    n_vec++;
    if (bus_a.s_we !== 1'b1) begin
      n_bad++; $display("FAIL route_we: got %b want 1", bus_a.s_we);
    end
    bus_a.s_dat_i = 32'hCAFE_F00D;
    bus_a.s_ack   = 1'b1;
    #1;
    n_vec++;
    if (bus_a.m_ack !== 2'b10) begin
      n_bad++; $display("FAIL route_ack: got %b want 10", bus_a.m_ack);
    end
    n_vec++;
    if (bus_a.m_dat_i !== 32'hCAFE_F00D) begin
      n_bad++; $display("FAIL route_rdata: got %h want cafef00d", bus_a.m_dat_i);
    end
    tick();
    bus_a.s_ack = 1'b0;
    bus_a.m_cyc = 2'b00;
    bus_a.m_stb = 2'b00;
    tick();
    n_vec++;
    if (bus_a.s_adr !== 32'h0) begin
      n_bad++; $display("FAIL idle_adr_zero: got %h want 00000000", bus_a.s_adr);
    end
    bus_a.m_we = 2'b00;
    tick();
  endtask

  task automatic test_burst_lock();
    bus_a.m_cyc = 2'b01;
    bus_a.m_stb = 2'b01;
    tick();
    bus_a.m_cyc = 2'b11;
    bus_a.m_stb = 2'b11;
    bus_a.s_ack = 1'b1;
    for (int b = 0; b < 4; b++) begin
      #1;
      n_vec++;
      if ({bus_a.grant, bus_a.m_ack} !== 4'b0101) begin
        n_bad++; $display("FAIL burst_beat%0d: got grant/ack %b want 0101", b, {bus_a.grant, bus_a.m_ack});
      end
      @(posedge clk);
    end
    #1;
    bus_a.s_ack = 1'b0;
    bus_a.m_cyc = 2'b10;
    bus_a.m_stb = 2'b10;
    tick();
    n_vec++;
    if (bus_a.grant !== 2'b00) begin
      n_bad++; $display("FAIL burst_gap: got %b want 00", bus_a.grant);
    end
    tick();
    n_vec++;
    if (bus_a.grant !== 2'b10) begin
      n_bad++; $display("FAIL burst_next_owner: got %b want 10", bus_a.grant);
    end
    bus_a.m_cyc = 2'b00;
    bus_a.m_stb = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    bus_a.m_cyc = 2'b01;
    bus_a.m_stb = 2'b01;
    bus_a.s_ack = 1'b0;
    tick();
    for (int c = 1; c < 8; c++) begin
      n_vec++;
      if (bus_a.m_err !== 2'b00) begin
        n_bad++; $display("FAIL timeout_early_c%0d: got %b want 00", c, bus_a.m_err);
      end
      tick();
    end
    n_vec++;
    if (bus_a.m_err !== 2'b01) begin
      n_bad++; $display("FAIL timeout_err: got %b want 01", bus_a.m_err);
    end
    n_vec++;
    if ({bus_a.s_cyc, bus_a.s_stb} !== 2'b00) begin
      n_bad++; $display("FAIL timeout_s_cyc: got %b want 00", {bus_a.s_cyc, bus_a.s_stb});
    end
    tick();
    n_vec++;
    if ({bus_a.grant, bus_a.m_err} !== 4'b0000) begin
      n_bad++; $display("FAIL timeout_idle: got grant/err %b want 0000", {bus_a.grant, bus_a.m_err});
    end
    bus_a.m_cyc = 2'b00;
    bus_a.m_stb = 2'b00;
    tick();
    // Same stall, but ACK arrives on the last allowed cycle.
    bus_a.m_cyc = 2'b01;
    bus_a.m_stb = 2'b01;
    tick();
    for (int c = 1; c < 8; c++) tick();
    bus_a.s_ack = 1'b1;
    #1;
    n_vec++;
    if ({bus_a.m_ack, bus_a.m_err} !== 4'b0100) begin
      n_bad++; $display("FAIL timeout_ack_wins: got ack/err %b want 0100", {bus_a.m_ack, bus_a.m_err});
    end
    tick();
    n_vec++;
    if (bus_a.grant !== 2'b01) begin
      n_bad++; $display("FAIL timeout_ack_hold: got %b want 01", bus_a.grant);
    end
    bus_a.s_ack = 1'b0;
    bus_a.m_cyc = 2'b00;
    bus_a.m_stb = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rr [5];
    exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bus_b.m_cyc = 4'b1111;
    bus_b.m_stb = 4'b1111;
    bus_b.s_ack = 1'b0;
    tick();
    for (int r = 0; r < 5; r++) begin
      n_vec++;
      if (bus_b.grant !== exp_rr[r]) begin
        n_bad++; $display("FAIL rr_grant%0d: got %b want %b", r, bus_b.grant, exp_rr[r]);
      end
      if (r < 4) begin
        bus_b.s_ack = 1'b1;
        #1;
        n_vec++;
        if (bus_b.m_ack !== exp_rr[r]) begin
          n_bad++; $display("FAIL rr_ack%0d: got %b want %b", r, bus_b.m_ack, exp_rr[r]);
        end
        tick();
        bus_b.s_ack = 1'b0;
        bus_b.m_cyc = 4'b1111 & ~exp_rr[r];
        bus_b.m_stb = 4'b1111 & ~exp_rr[r];
        tick();
        n_vec++;
        if (bus_b.grant !== 4'b0000) begin
          n_bad++; $display("FAIL rr_gap%0d: got %b want 0000", r, bus_b.grant);
        end
        bus_b.m_cyc = 4'b1111;
        bus_b.m_stb = 4'b1111;
        tick();
      end
    end
  endtask

  task automatic test_reset_mid();
    // dut_b is still granted to master 0 with STB up and no ACK.
    rst_b = 1'b1;
    #1;
    n_vec++;
    if ({bus_b.grant, bus_b.s_cyc} !== 5'b00000) begin
      n_bad++; $display("FAIL midrst_clear: got grant/s_cyc %b want 00000", {bus_b.grant, bus_b.s_cyc});
    end
    tick();
    rst_b = 1'b0;
    tick();
    n_vec++;
    if (bus_b.grant !== 4'b0001) begin
      n_bad++; $display("FAIL midrst_rr_restart: got %b want 0001", bus_b.grant);
    end
    bus_b.m_cyc = 4'b0000;
    bus_b.m_stb = 4'b0000;
    tick();
    tick();
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.m_cyc   = '0;
    bus_a.m_stb   = '0;
    bus_a.m_we    = '0;
    bus_a.m_adr   = '0;
    bus_a.m_dat_o = '0;
    bus_a.s_dat_i = '0;
    bus_a.s_ack   = 1'b0;
    bus_b.m_cyc   = '0;
    bus_b.m_stb   = '0;
    bus_b.m_we    = '0;
    bus_b.m_adr   = '0;
    bus_b.m_dat_o = '0;
    bus_b.s_dat_i = '0;
    bus_b.s_ack   = 1'b0;

    test_reset();
    test_fixed_prio();
    test_routing();
    test_burst_lock();
    test_timeout();
    test_round_robin();
    test_reset_mid();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
